genie_split: RTL
================

# genie_split

Packet-aware 1-to-NO splitter: the transmit-side counterpart of the NI-to-1 merge arbiter. It takes one valid/ready/eop stream and delivers each packet to the outputs selected by a destination mask, which is sampled on the packet's first beat. Unicast and multicast are both supported. One output register stage decouples the input from the outputs. Full throughput is sustained while every addressed output is ready.

## Interface
- NO, default 1: number of outputs; must be ≥ 1.
- WIDTH, default 1: data width in bits.

- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- i_data  in  WIDTH  input beat data
- i_valid  in  1  input beat valid
- o_ready  out  1  input may advance this cycle
- i_eop  in  1  last beat of packet
- i_mask  in  NO  destination mask; bit k addresses output k; sampled only on the first beat of a packet
- o_valid  out  NO  per-output valid
- o_data  out  WIDTH  shared output data, common to all outputs
- o_eop  out  1  shared output eop
- i_ready  in  NO  per-output ready

## Operation
- Internal state:
  - buf_data[WIDTH] and buf_eop: the beat register.
  - pend[NO]: outputs that have not yet taken the buffered beat.
  - pkt_mask[NO]: mask held for the current packet.
  - FSM state.
- Output mapping:
  - o_valid = pend.
  - o_data = buf_data; o_eop = buf_eop.
- Retire: output k takes the beat when pend[k] && i_ready[k]. Then pend[k] clears and o_valid[k] stays low until the next beat loads.
- Ready: o_ready = !reset && ((pend & ~i_ready) == 0).
  - Asserted when the register is empty, or when it empties this cycle.
  - Combinational from i_ready and pend. Does not depend on i_valid.
- Accept: an input beat is accepted when i_valid && o_ready.
- Effective mask (eff_mask):
  - S_IDLE: eff_mask = i_mask.
  - S_LOCKED: eff_mask = pkt_mask. i_mask is ignored.
- On accept:
  - buf_data <= i_data; buf_eop <= i_eop; pend <= eff_mask.
  - This overrides the retire-clear of the same cycle.
- No accept: pend <= pend & ~i_ready. buf_data and buf_eop hold.
- FSM:
  - S_IDLE: on accept, pkt_mask <= i_mask. If !i_eop, go to S_LOCKED. A single-beat packet stays in S_IDLE.
  - S_LOCKED: on accept with i_eop, go to S_IDLE. pkt_mask holds.
- Zero mask: beats are accepted and dropped. pend loads 0, nothing is presented, and the FSM still tracks eop.
- Multicast: a beat stays registered until every addressed output has taken it.
  - Outputs may take the beat in different cycles.
  - o_data and o_eop are stable the whole time any pend bit is set.
- No reordering and no interleaving: outputs see packets in input order, contiguously.
- NO = 1: pend is 1 bit and behaves as a single-entry pipeline register.

## Timing
- Latency: a beat accepted in cycle t appears on o_valid in cycle t+1.
- Throughput: one beat per cycle while every addressed output holds i_ready high.
- Reset (asynchronous, takes effect immediately):
  - pend = 0, so o_valid = 0.
  - buf_data = 0, so o_data = 0; buf_eop = 0, so o_eop = 0.
  - pkt_mask = 0; state = S_IDLE.
  - o_ready = 0 while reset is high. After release it is 1, because pend = 0.
- Reset mid-packet: any partially delivered beat is discarded. The next accepted beat is treated as a first beat and i_mask is sampled.
- o_valid[k] never drops once asserted until output k takes the beat, whatever i_valid does.
- Simultaneous retire and accept in the same cycle: the new beat wins. pend takes eff_mask with no bubble.

## Test plan
Bench parameters: NO=4, WIDTH=8.

- Unicast, one packet: 3-beat packet 0x11/0x22/0x33(eop), i_mask=4'b0100 on beat 0, i_mask=4'b0001 on later beats, all i_ready=1. Required: o_valid=4'b0100 for 3 consecutive cycles starting 1 cycle after beat 0; o_eop only with 0x33; o_ready stays 1.
- Multicast, staggered readiness: 1-beat packet 0xA5(eop), i_mask=4'b1011. i_ready[0] high immediately, i_ready[1] 2 cycles later, i_ready[3] 4 cycles later. Required: o_valid steps 1011→1010→1000→0000; o_data=0xA5 throughout; o_ready=0 until the cycle i_ready[3] rises.
- Back-to-back packets: packet 0x01(eop) with mask 4'b0001, immediately followed by packet 0x02/0x03(eop) with mask 4'b0010. Required: o_valid 0001, 0010, 0010 in consecutive cycles with no bubble; second packet's i_mask change on its beat 1 is ignored.
- Backpressure mid-packet: 4-beat packet to 4'b1000 with i_ready[3] toggling 1,0,0,1,1,… Required: o_data holds each beat while stalled; o_ready=0 exactly in the stall cycles; all 4 beats delivered in order, no duplicates.
- Zero mask: 2-beat packet with i_mask=0, then 1-beat packet 0x77 with mask 4'b0100. Required: o_valid stays 0 for the first packet; o_ready stays 1; 0x77 appears on output 2 only.
- Reset mid-packet: assert reset after beat 1 of a 3-beat packet. Required: o_valid=0, o_data=0, o_eop=0 and o_ready=0 during reset. The next beat after release samples a new i_mask=4'b0010 and routes to output 2'b01 index 1.

Source files
------------

// File: rtl/genie_split.sv
// genie_split: packet-aware 1-to-NO splitter. A destination mask is latched on each
// packet's first beat, and one register stage holds every beat until all addressed outputs take it.

module genie_split_lane (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic load_bit,
  input  logic ready,
  output logic pend,
  output logic stall
);

  // A new beat overrides the retire-clear of the same cycle, so there is no bubble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      pend <= 1'b0;
    else if (load)  pend <= load_bit;
    else if (ready) pend <= 1'b0;
  end

  assign stall = pend & ~ready;

endmodule

module genie_split #(
  parameter int NO    = 1,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic             i_eop,
  input  logic [NO-1:0]    i_mask,
  output logic [NO-1:0]    o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic             o_eop,
  input  logic [NO-1:0]    i_ready
);

  typedef enum logic {S_IDLE, S_LOCKED} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             eop;
  } beat_t;

  state_t        state_q, state_d;
  beat_t         buf_q;
  logic [NO-1:0] pend, stall, eff_mask, pkt_mask;
  logic          accept;

  // The register can take a new beat once every still-pending output is taking the current one.
  assign o_ready = !reset && (stall == '0);
  assign accept  = i_valid && o_ready;

  genvar k;
  generate
    for (k = 0; k < NO; k++) begin : g_lane
      genie_split_lane u_lane (
        .clk      (clk),
        .reset    (reset),
        .load     (accept),
        .load_bit (eff_mask[k]),
        .ready    (i_ready[k]),
        .pend     (pend[k]),
        .stall    (stall[k])
      );
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    eff_mask = i_mask;
    case (state_q)
      S_IDLE: begin
        if (accept && !i_eop) state_d = S_LOCKED;
      end
      S_LOCKED: begin
        eff_mask = pkt_mask;
        if (accept && i_eop) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                          pkt_mask <= '0;
    else if (accept && state_q == S_IDLE) pkt_mask <= i_mask;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       buf_q <= '0;
    else if (accept) buf_q <= '{data: i_data, eop: i_eop};
  end

  assign o_valid = pend;
  assign o_data  = buf_q.data;
  assign o_eop   = buf_q.eop;

endmodule
